// File: rtl/dma_csr_bridge_if.sv
// AXI4-Lite slave bus bundle for the DMA CSR bridge, plus the CSR-side
// request/response types shared by the bridge and its CSR block.

package dma_csr_pkg;
  // Strobe and payload toward the DMA CSR block
  typedef struct packed {
    logic        csr_wr_en;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_rd_en;
  } csr_req_t;

  // Full 64-byte CSR window image returned by the CSR block
  typedef struct packed {
    logic [511:0] csr_rdata;
  } csr_resp_t;
endpackage

interface dma_csr_bridge_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dma_csr_bridge.sv
// AXI4-Lite to DMA CSR bridge. One transaction at a time; writes win over
// reads when both arrive together. Accesses outside the window, misaligned,
// or (for writes) with partial strobes get SLVERR with unchanged latency and
// never touch the CSR block.

module dma_csr_bridge
  import dma_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2004_0000,
  parameter int          WIN_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  dma_csr_bridge_if.slave       axi,
  output csr_req_t              csr_req,
  input  csr_resp_t             csr_resp
);

  localparam int IDX_W = WIN_BITS - 2;

  typedef enum logic [2:0] {
    IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_CAP, RD_RESP
  } state_t;

  state_t state_q, state_d;

  logic              idle, wr_hs, rd_hs;
  logic [31:0]       addr_p0;
  logic [31:0]       wdata_p0;
  logic              legal_p0;
  logic [31:0]       rdata_p2;

  // Inside the CSR window and word aligned
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) && (a[1:0] == 2'b00);
  endfunction

  // Pick one 32-bit register out of the window image
  function automatic logic [31:0] sel_word(input logic [511:0] img,
                                           input logic [IDX_W-1:0] idx);
    return img[32*idx +: 32];
  endfunction

  // Handshakes only in IDLE and never while reset is held
  assign idle  = (state_q == IDLE) && !rst;
  assign wr_hs = idle && axi.awvalid && axi.wvalid;
  assign rd_hs = idle && axi.arvalid && !(axi.awvalid && axi.wvalid);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture (p0): address and write data, no reset needed
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      addr_p0  <= axi.awaddr;
      wdata_p0 <= axi.wdata;
    end else if (rd_hs) begin
      addr_p0  <= axi.araddr;
    end
  end

  // Legality at handshake (p0) and read data capture in RD_CAP (p2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      legal_p0 <= 1'b0;
      rdata_p2 <= '0;
    end else begin
      if (wr_hs)      legal_p0 <= addr_ok(axi.awaddr) && (axi.wstrb == 4'hF);
      else if (rd_hs) legal_p0 <= addr_ok(axi.araddr);
      if (state_q == RD_CAP)
        rdata_p2 <= legal_p0 ? sel_word(csr_resp.csr_rdata, addr_p0[WIN_BITS-1:2]) : 32'h0;
    end
  end

  // Next state and all bus/CSR outputs
  always_comb begin
    state_d     = state_q;
    axi.awready = wr_hs;
    axi.wready  = wr_hs;
    axi.arready = rd_hs;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.rvalid  = 1'b0;
    axi.rresp   = 2'b00;
    axi.rdata   = 32'h0;
    csr_req     = '0;
    case (state_q)
      IDLE: begin
        if (wr_hs)      state_d = WR_EXEC;
        else if (rd_hs) state_d = RD_EXEC;
      end
      WR_EXEC: begin
        csr_req.csr_wr_en = legal_p0;
        if (legal_p0) begin
          csr_req.csr_waddr = addr_p0;
          csr_req.csr_wdata = wdata_p0;
        end
        state_d = WR_RESP;
      end
      WR_RESP: begin
        axi.bvalid = 1'b1;
        axi.bresp  = legal_p0 ? 2'b00 : 2'b10;
        if (axi.bready) state_d = IDLE;
      end
      RD_EXEC: begin
        csr_req.csr_rd_en = legal_p0;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        state_d = RD_RESP;
      end
      RD_RESP: begin
        axi.rvalid = 1'b1;
        axi.rresp  = legal_p0 ? 2'b00 : 2'b10;
        axi.rdata  = rdata_p2;
        if (axi.rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_csr_bridge.sv
// Bench for dma_csr_bridge: a simple CSR register file model sits behind the
// bridge, and a transaction-level reference (window arithmetic plus an
// expected register array) predicts every response.

module tb_dma_csr_bridge;
  import dma_csr_pkg::*;

  localparam logic [31:0] BASE = 32'h2004_0000;

  logic      clk = 1'b0;
  logic      rst;
  csr_req_t  csr_req;
  csr_resp_t csr_resp;

  always #5 clk = ~clk;

  dma_csr_bridge_if bus();

  dma_csr_bridge #(.BASE_ADDR(BASE), .WIN_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .axi      (bus.slave),
    .csr_req  (csr_req),
    .csr_resp (csr_resp)
  );

  // CSR block model: 16 registers, preload port, strobe counters
  logic [31:0] img [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;
  int          wr_cnt, rd_cnt, both_cnt;

  always @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= 0;
      rd_cnt   <= 0;
      both_cnt <= 0;
    end else begin
      if (csr_req.csr_wr_en) wr_cnt <= wr_cnt + 1;
      if (csr_req.csr_rd_en) rd_cnt <= rd_cnt + 1;
      if (csr_req.csr_wr_en && csr_req.csr_rd_en) both_cnt <= both_cnt + 1;
    end
    if (pl_en)                  img[pl_idx] <= pl_data;
    else if (csr_req.csr_wr_en) img[csr_req.csr_waddr[5:2]] <= csr_req.csr_wdata;
  end

  always_comb begin
    csr_resp = '0;
    for (int i = 0; i < 16; i++) csr_resp.csr_rdata[32*i +: 32] = img[i];
  end

  // Reference state
  logic [31:0] exp_mem [16];
  int exp_wr, exp_rd;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [3:0] s, input bit wr);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < 64) && (off % 4 == 0) && (!wr || s == 4'hF);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 15;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 64'(bus.awready), 0);
    check({tag, "_wready"},  64'(bus.wready),  0);
    check({tag, "_arready"}, 64'(bus.arready), 0);
    check({tag, "_bvalid"},  64'(bus.bvalid),  0);
    check({tag, "_bresp"},   64'(bus.bresp),   0);
    check({tag, "_rvalid"},  64'(bus.rvalid),  0);
    check({tag, "_rresp"},   64'(bus.rresp),   0);
    check({tag, "_rdata"},   64'(bus.rdata),   0);
    check({tag, "_csr_req"}, 64'(csr_req != '0), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
    check({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(exp_rd));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int dly);
    bit lg;
    lg = is_legal(a, s, 1'b1);
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = (dly == 0);
    #1;
    check("wr_awready", 64'(bus.awready), 1);
    check("wr_wready",  64'(bus.wready),  1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.awaddr = $urandom; bus.wdata = $urandom; bus.wstrb = 4'($urandom);
    @(negedge clk);
    check("wr_en",       64'(csr_req.csr_wr_en), 64'(lg));
    check("wr_waddr",    64'(csr_req.csr_waddr), lg ? 64'(a) : 64'd0);
    check("wr_wdata",    64'(csr_req.csr_wdata), lg ? 64'(d) : 64'd0);
    check("wr_no_rd_en", 64'(csr_req.csr_rd_en), 0);
    check("wr_bvalid_early", 64'(bus.bvalid), 0);
    @(negedge clk);
    check("wr_bvalid", 64'(bus.bvalid), 1);
    check("wr_bresp",  64'(bus.bresp), lg ? 64'd0 : 64'd2);
    check("wr_en_once", 64'(csr_req.csr_wr_en), 0);
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk);
      check("wr_bvalid_hold", 64'(bus.bvalid), 1);
      check("wr_bresp_hold",  64'(bus.bresp), lg ? 64'd0 : 64'd2);
      if (i == dly) bus.bready = 1'b1;
    end
    @(negedge clk);
    check("wr_bvalid_done", 64'(bus.bvalid), 0);
    bus.bready = 1'b0;
    if (lg) begin
      exp_mem[word_of(a)] = d;
      exp_wr++;
    end
    check_counts("wr");
  endtask

  task automatic do_read(input logic [31:0] a, input int dly);
    bit lg;
    logic [31:0] exp;
    lg  = is_legal(a, 4'hF, 1'b0);
    exp = lg ? exp_mem[word_of(a)] : 32'h0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = (dly == 0);
    #1;
    check("rd_arready", 64'(bus.arready), 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.araddr = $urandom;
    @(negedge clk);
    check("rd_en",       64'(csr_req.csr_rd_en), 64'(lg));
    check("rd_no_wr_en", 64'(csr_req.csr_wr_en), 0);
    check("rd_rvalid_t1", 64'(bus.rvalid), 0);
    @(negedge clk);
    check("rd_en_once",   64'(csr_req.csr_rd_en), 0);
    check("rd_rvalid_t2", 64'(bus.rvalid), 0);
    @(negedge clk);
    check("rd_rvalid", 64'(bus.rvalid), 1);
    check("rd_rdata",  64'(bus.rdata), 64'(exp));
    check("rd_rresp",  64'(bus.rresp), lg ? 64'd0 : 64'd2);
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk);
      check("rd_rvalid_hold", 64'(bus.rvalid), 1);
      check("rd_rdata_hold",  64'(bus.rdata), 64'(exp));
      check("rd_rresp_hold",  64'(bus.rresp), lg ? 64'd0 : 64'd2);
      if (i == dly) bus.rready = 1'b1;
    end
    @(negedge clk);
    check("rd_rvalid_done", 64'(bus.rvalid), 0);
    bus.rready = 1'b0;
    if (lg) exp_rd++;
    check_counts("rd");
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 5)
      0, 1:    return BASE + 32'(($urandom % 16) * 4);
      2:       return BASE + 32'd64 + 32'(($urandom % 64) * 4);
      3:       return BASE - 32'(4 * (1 + $urandom % 8));
      default: return BASE + 32'(($urandom % 16) * 4) + 32'(1 + $urandom % 3);
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    exp_wr = 0; exp_rd = 0;

    // Preload the register file while reset is held, with valids asserted
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 4'(i);
      pl_data = (i == 5) ? 32'h1234_5678 : $urandom;
      exp_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.awaddr = BASE; bus.araddr = BASE; bus.wstrb = 4'hF;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    rst = 1'b0;

    // Directed: basic write, preloaded read, illegal accesses, long stall
    do_write(BASE + 32'h08, 32'hDEAD_BEEF, 4'hF, 0);
    do_read (BASE + 32'h14, 0);
    do_read (BASE + 32'h08, 0);
    do_write(BASE + 32'h40, 32'hCAFE_0001, 4'hF, 0);
    do_write(BASE + 32'h0C, 32'hCAFE_0002, 4'h3, 1);
    do_read (BASE + 32'h02, 0);
    do_read (BASE + 32'h14, 5);
    do_read (BASE + 32'h3C, 2);

    // Simultaneous write and read: write first, read after B handshake
    d = $urandom;
    @(negedge clk);
    bus.awaddr = BASE + 32'h0C; bus.wdata = d; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = BASE + 32'h0C; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    #1;
    check("col_awready", 64'(bus.awready), 1);
    check("col_arready", 64'(bus.arready), 0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("col_wr_en",      64'(csr_req.csr_wr_en), 1);
    check("col_arready_t1", 64'(bus.arready), 0);
    @(negedge clk);
    check("col_bvalid",     64'(bus.bvalid), 1);
    check("col_arready_t2", 64'(bus.arready), 0);
    @(negedge clk);
    check("col_bvalid_done", 64'(bus.bvalid), 0);
    check("col_arready_t3",  64'(bus.arready), 1);
    exp_mem[3] = d; exp_wr++;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("col_rd_en", 64'(csr_req.csr_rd_en), 1);
    @(negedge clk);
    @(negedge clk);
    check("col_rvalid", 64'(bus.rvalid), 1);
    check("col_rdata",  64'(bus.rdata), 64'(d));
    @(negedge clk);
    check("col_rvalid_done", 64'(bus.rvalid), 0);
    bus.bready = 1'b0; bus.rready = 1'b0;
    exp_rd++;
    check_counts("col");

    // Reset during RD_EXEC abandons the read
    @(negedge clk);
    bus.araddr = BASE + 32'h14; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("rst_rd_en_before", 64'(csr_req.csr_rd_en), 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    exp_wr = 0; exp_rd = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", 64'(bus.rvalid), 0);
      check("post_rst_rd_en",  64'(csr_req.csr_rd_en), 0);
    end
    check_counts("post_rst");

    // Randomized mix of legal and illegal reads and writes
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = rand_addr();
      s = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
      if ($urandom % 2) do_write(a, $urandom, s, int'($urandom % 4));
      else              do_read(a, int'($urandom % 4));
      if ($urandom % 3 == 0) @(negedge clk);
    end

    check("both_strobes", 64'(both_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
